sgd_job_ctrl: RTL and testbench
===============================

SGD_JOB_CTRL -- requirements
Module: sgd_job_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the dataset RAM address width.
REQ-002 Parameter DATA_WIDTH, default 256, sets the data point width: 16-bit Y in the MSBs, then up to 15 16-bit features.
REQ-003 Parameter WD_SLACK, default 16, sets the extra cycles allowed by the watchdog.
REQ-004 CLK  in  1  clock; reset RST, synchronous, active-high.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 cfg_valid in 1 / cfg_ready out 1  configuration handshake.
REQ-007 cfg_feat in 4, cfg_points in ADDR_WIDTH, cfg_epoch in 8, cfg_lr in 4  job parameters.
REQ-008 ld_valid in 1 / ld_ready out 1 / ld_data in DATA_WIDTH / ld_last in 1  dataset load stream.
REQ-009 start in 1, abort in 1  job control pulses.
REQ-010 ram_we out 1, ram_addr out ADDR_WIDTH, ram_wdata out DATA_WIDTH  single-port dataset RAM port.
REQ-011 eng_addr in ADDR_WIDTH, eng_done in 1  from the SGD engine.
REQ-012 eng_rst out 1, eng_hold out 1, eng_feat out 4, eng_points out ADDR_WIDTH, eng_epoch out 8, eng_lr out 4  to the SGD engine.
REQ-013 busy out 1, done out 1, err out 2  status: 0 none, 1 bad config, 2 short load, 3 timeout.

Function
REQ-014 States SHALL be IDLE, LOAD, ARM, RUN, DONE, ERR, encoded in the shared package.
REQ-015 IDLE: cfg_ready=1; a cfg handshake latches all four cfg fields into registers that drive the eng_* outputs continuously.
REQ-016 Config check: cfg_points==0, cfg_feat==0 or cfg_epoch==0 -> ERR with err=1; otherwise -> LOAD, load counter=0, err=0, done=0.
REQ-017 LOAD: ld_ready=1; each ld handshake SHALL drive, in the next cycle, ram_we=1, ram_addr=counter and ram_wdata=ld_data (registered), then increment the counter.
REQ-018 LOAD exits to ARM on the handshake where counter==cfg_points-1; ld_last is ignored on that beat.
REQ-019 An ld_last beat with counter<cfg_points-1 SHALL still be written, then -> ERR with err=2.
REQ-020 ARM: eng_rst=1; start is honoured only after eng_rst has been high >=2 consecutive cycles; start arriving earlier is held pending.
REQ-021 RUN: eng_rst=0, ram_we=0, ram_addr=eng_addr (combinational mux); ld_ready=0.
REQ-022 RUN -> DONE on the first cycle with eng_done=1; done=1 is held until the next accepted cfg handshake.
REQ-023 Watchdog: a 24-bit counter is cleared on RUN entry; reaching 4*cfg_points*cfg_epoch+WD_SLACK -> ERR with err=3, with eng_hold=1 for exactly one cycle.
REQ-024 abort in any state other than IDLE -> IDLE next cycle; eng_hold pulses 1 cycle if the state was RUN; err is unchanged.
REQ-025 abort takes priority over eng_done, the watchdog and the load-complete condition in the same cycle.
REQ-026 eng_rst=1 in every state except RUN; busy=1 in LOAD, ARM and RUN.
REQ-027 DONE and ERR return to IDLE on the next cfg handshake (cfg_ready=1 in these states) or on abort.
REQ-028 A cfg_valid arriving outside IDLE/DONE/ERR SHALL NOT be accepted (cfg_ready=0).

Reset
REQ-029 RST: state=IDLE; all counters=0; cfg registers=0; ram_we=0; eng_rst=1; eng_hold=0; done=0; err=0; busy=0.
REQ-030 RST during LOAD or RUN SHALL abandon the job without completing any pending RAM write.

Structure
REQ-031 The state encoding, err codes and the WD_SLACK default SHALL live in shared package sgd_pkg.
REQ-032 The watchdog SHALL be a sub-module sgd_watchdog (clear, enable, 24-bit limit, expire pulse).

Verification
REQ-033 Scenario: cfg points=4, feat=2, epoch=3, then 4 beats -> ram_we at addresses 0..3; eng_done -> done=1, err=0.
REQ-034 Scenario: cfg points=0 -> err=1 the next cycle, ld_ready=0.
REQ-035 Scenario: points=8 with ld_last on beat 5 -> 5 writes (addresses 0..4), err=2.
REQ-036 Scenario: points=2, epoch=1, eng_done tied 0 -> err=3 after 24 RUN cycles, with a 1-cycle eng_hold.
REQ-037 Scenario: abort in RUN on the same cycle as eng_done -> IDLE, done=0, eng_hold pulse.
REQ-038 Scenario: start pulsed on the first ARM cycle -> RUN entered no earlier than the 3rd ARM cycle.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD job controller: FSM states, error codes,
// watchdog sizing and the watchdog limit helper.
package sgd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } sgd_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CFG     = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } sgd_err_e;

  localparam int unsigned WD_SLACK_DEF = 16;
  localparam int unsigned WD_WIDTH     = 24;

  // Watchdog budget: four cycles per point per epoch plus a fixed slack.
  function automatic logic [WD_WIDTH-1:0] wd_limit(
    input logic [WD_WIDTH-1:0] points,
    input logic [WD_WIDTH-1:0] epoch,
    input logic [WD_WIDTH-1:0] slack
  );
    logic [WD_WIDTH-1:0] prod_s;
    prod_s = points * epoch;
    return {prod_s[WD_WIDTH-3:0], 2'b00} + slack;
  endfunction

endpackage

// File: rtl/sgd_watchdog.sv
// Run-time watchdog: counts enabled cycles since the last clear and pulses
// expire on the cycle in which the count reaches the limit.
module sgd_watchdog
  import sgd_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                enable,
  input  logic [WD_WIDTH-1:0] limit,
  output logic                expire
);

  logic [WD_WIDTH-1:0] cnt_r;

  // Cycle counter: restarts on clear, advances while enabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {WD_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {WD_WIDTH{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + WD_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expire pulse on the enabled cycle whose increment reaches the limit.
  always_comb begin
    expire = 1'b0;
    if (enable && !clear && ((cnt_r + WD_WIDTH'(1)) == limit)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/sgd_job_ctrl.sv
// SGD job controller: accepts a job configuration, streams the dataset into
// RAM, sequences the engine reset/start and supervises the run.
module sgd_job_ctrl
  import sgd_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256,
  parameter int WD_SLACK   = WD_SLACK_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_feat,
  input  logic [ADDR_WIDTH-1:0] cfg_points,
  input  logic [7:0]            cfg_epoch,
  input  logic [3:0]            cfg_lr,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic                  eng_done,
  output logic                  eng_rst,
  output logic                  eng_hold,
  output logic [3:0]            eng_feat,
  output logic [ADDR_WIDTH-1:0] eng_points,
  output logic [7:0]            eng_epoch,
  output logic [3:0]            eng_lr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  sgd_state_e            state_r, state_nxt_s;
  logic [3:0]            feat_r, lr_r;
  logic [ADDR_WIDTH-1:0] points_r, cnt_r, ram_addr_r;
  logic [7:0]            epoch_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic                  ram_we_r, arm_seen_r, start_pend_r;
  logic                  done_r, eng_hold_r;
  logic [1:0]            err_r;
  logic                  in_run_s, cfg_acc_s, cfg_bad_s, ld_acc_s, load_end_s;
  logic                  go_s, hold_s, wd_expire_s;
  logic [WD_WIDTH-1:0]   wd_limit_s;

  assign in_run_s   = (state_r == ST_RUN);
  assign cfg_ready  = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR);
  assign ld_ready   = (state_r == ST_LOAD);
  assign cfg_acc_s  = cfg_valid && cfg_ready;
  assign cfg_bad_s  = (cfg_points == ADDR_ZERO) || (cfg_feat == 4'd0) || (cfg_epoch == 8'd0);
  assign ld_acc_s   = ld_valid && ld_ready && !abort;
  assign load_end_s = (cnt_r == (points_r - ADDR_ONE));
  // arm_seen_r marks that eng_rst has already been high for one full ARM cycle.
  assign go_s       = arm_seen_r && (start || start_pend_r);
  assign wd_limit_s = wd_limit(WD_WIDTH'(points_r), WD_WIDTH'(epoch_r), WD_WIDTH'(WD_SLACK));

  sgd_watchdog u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (!in_run_s),
    .enable (in_run_s),
    .limit  (wd_limit_s),
    .expire (wd_expire_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks completion, eng_done and the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    hold_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_acc_s) state_nxt_s = cfg_bad_s ? ST_ERR : ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)                       state_nxt_s = ST_IDLE;
        else if (ld_acc_s && load_end_s) state_nxt_s = ST_ARM;
        else if (ld_acc_s && ld_last)    state_nxt_s = ST_ERR;
        else                             state_nxt_s = ST_LOAD;
      end
      ST_ARM: begin
        if (abort)     state_nxt_s = ST_IDLE;
        else if (go_s) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_ARM;
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          hold_s      = 1'b1;
        end else if (eng_done) begin
          state_nxt_s = ST_DONE;
        end else if (wd_expire_s) begin
          state_nxt_s = ST_ERR;
          hold_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE, ST_ERR: begin
        if (abort || cfg_acc_s) state_nxt_s = ST_IDLE;
        else                    state_nxt_s = state_r;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Job configuration registers, captured on an IDLE handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      feat_r   <= 4'd0;
      points_r <= ADDR_ZERO;
      epoch_r  <= 8'd0;
      lr_r     <= 4'd0;
    end else if ((state_r == ST_IDLE) && cfg_acc_s) begin
      feat_r   <= cfg_feat;
      points_r <= cfg_points;
      epoch_r  <= cfg_epoch;
      lr_r     <= cfg_lr;
    end else begin
      feat_r   <= feat_r;
      points_r <= points_r;
      epoch_r  <= epoch_r;
      lr_r     <= lr_r;
    end
  end

  // Dataset write port: each accepted beat is written one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_we_r    <= 1'b0;
      ram_addr_r  <= ADDR_ZERO;
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
      cnt_r       <= ADDR_ZERO;
    end else begin
      ram_we_r <= ld_acc_s;
      if (ld_acc_s) begin
        ram_addr_r  <= cnt_r;
        ram_wdata_r <= ld_data;
        cnt_r       <= cnt_r + ADDR_ONE;
      end else if ((state_r == ST_IDLE) && cfg_acc_s) begin
        ram_addr_r  <= ram_addr_r;
        ram_wdata_r <= ram_wdata_r;
        cnt_r       <= ADDR_ZERO;
      end else begin
        ram_addr_r  <= ram_addr_r;
        ram_wdata_r <= ram_wdata_r;
        cnt_r       <= cnt_r;
      end
    end
  end

  // ARM sequencing: remember an early start until the engine reset has settled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      arm_seen_r   <= 1'b0;
      start_pend_r <= 1'b0;
    end else begin
      arm_seen_r   <= (state_r == ST_ARM);
      start_pend_r <= (state_r == ST_ARM) && (start || start_pend_r);
    end
  end

  // Status: done, error code and the one-cycle engine hold pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_r     <= 1'b0;
      err_r      <= ERR_NONE;
      eng_hold_r <= 1'b0;
    end else begin
      eng_hold_r <= hold_s;
      if (cfg_acc_s)                               done_r <= 1'b0;
      else if (in_run_s && state_nxt_s == ST_DONE) done_r <= 1'b1;
      else                                         done_r <= done_r;
      if ((state_r == ST_IDLE) && cfg_acc_s)               err_r <= cfg_bad_s ? ERR_CFG : ERR_NONE;
      else if ((state_r == ST_LOAD) && state_nxt_s == ST_ERR) err_r <= ERR_SHORT;
      else if (in_run_s && state_nxt_s == ST_ERR)           err_r <= ERR_TIMEOUT;
      else                                                  err_r <= err_r;
    end
  end

  assign ram_we     = ram_we_r;
  assign ram_addr   = in_run_s ? eng_addr : ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign eng_rst    = !in_run_s;
  assign eng_hold   = eng_hold_r;
  assign eng_feat   = feat_r;
  assign eng_points = points_r;
  assign eng_epoch  = epoch_r;
  assign eng_lr     = lr_r;
  assign busy       = (state_r == ST_LOAD) || (state_r == ST_ARM) || in_run_s;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sgd_job_ctrl.sv
// Self-checking bench for sgd_job_ctrl: scenario tasks plus a RAM-write
// scoreboard fed by the beat driver and drained by a write monitor.
module tb_sgd_job_ctrl;

  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cfg_valid, cfg_ready;
  logic [3:0]    cfg_feat, cfg_lr;
  logic [AW-1:0] cfg_points;
  logic [7:0]    cfg_epoch;
  logic          ld_valid, ld_ready, ld_last;
  logic [DW-1:0] ld_data;
  logic          start, abort;
  logic          ram_we;
  logic [AW-1:0] ram_addr, eng_addr, eng_points;
  logic [DW-1:0] ram_wdata;
  logic          eng_done, eng_rst, eng_hold;
  logic [3:0]    eng_feat, eng_lr;
  logic [7:0]    eng_epoch;
  logic          busy, done;
  logic [1:0]    err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  tests_run = 0;
  int  fails     = 0;

  always #5 CLK = ~CLK;

  sgd_job_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WD_SLACK(16)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_feat(cfg_feat),
    .cfg_points(cfg_points), .cfg_epoch(cfg_epoch), .cfg_lr(cfg_lr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .start(start), .abort(abort),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .eng_addr(eng_addr), .eng_done(eng_done),
    .eng_rst(eng_rst), .eng_hold(eng_hold), .eng_feat(eng_feat),
    .eng_points(eng_points), .eng_epoch(eng_epoch), .eng_lr(eng_lr),
    .busy(busy), .done(done), .err(err)
  );

  // Every RAM write must match the oldest expected write.
  always @(negedge CLK) begin
    if (ram_we === 1'b1) begin
      wr_t e;
      tests_run++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL ram_write unexpected addr=%0d", ram_addr);
      end else begin
        e = wq.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          fails++;
          $display("FAIL ram_write got addr=%0d data=%h exp addr=%0d data=%h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RST = 1'b1; cfg_valid = 1'b0; cfg_feat = 4'd0; cfg_points = '0; cfg_epoch = 8'd0;
    cfg_lr = 4'd0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0;
    abort = 1'b0; eng_addr = '0; eng_done = 1'b0;
    tick; tick;
    RST = 1'b0;
  endtask

  task automatic send_cfg(input logic [AW-1:0] p, input logic [3:0] f,
                          input logic [7:0] e, input logic [3:0] l);
    cfg_valid = 1'b1; cfg_points = p; cfg_feat = f; cfg_epoch = e; cfg_lr = l;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input int idx, input logic last, input logic expect_wr);
    logic [DW-1:0] d;
    wr_t w;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    if (expect_wr) begin
      w.addr = AW'(idx); w.data = d;
      wq.push_back(w);
    end
    tick;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_run(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eng_rst === 1'b0) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    tests_run++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== 1'b0 || err !== 2'd0) begin fails++; $display("FAIL reset_status got done=%b err=%0d exp 0/0", done, err); end
    tests_run++; if (eng_rst !== 1'b1 || eng_hold !== 1'b0) begin fails++; $display("FAIL reset_eng got rst=%b hold=%b exp 1/0", eng_rst, eng_hold); end
    tests_run++; if (ram_we !== 1'b0 || ld_ready !== 1'b0) begin fails++; $display("FAIL reset_ports got we=%b ld_ready=%b exp 0/0", ram_we, ld_ready); end
    tests_run++; if (eng_points !== '0 || eng_epoch !== 8'd0) begin fails++; $display("FAIL reset_cfg_regs got pts=%0d ep=%0d exp 0/0", eng_points, eng_epoch); end
  endtask

  task automatic test_normal;
    logic ok;
    apply_reset;
    send_cfg(12'd4, 4'd2, 8'd3, 4'd5);
    tests_run++; if (ld_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL normal_load got ld_ready=%b busy=%b exp 1/1", ld_ready, busy); end
    tests_run++; if (eng_points !== 12'd4 || eng_feat !== 4'd2 || eng_epoch !== 8'd3 || eng_lr !== 4'd5) begin
      fails++; $display("FAIL normal_cfg got pts=%0d feat=%0d ep=%0d lr=%0d exp 4/2/3/5", eng_points, eng_feat, eng_epoch, eng_lr); end
    for (int i = 0; i < 4; i++) send_beat(i, 1'b0, 1'b1);
    start = 1'b1; tick; start = 1'b0;
    wait_run(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL normal_run_timeout got eng_rst=%b exp 0", eng_rst); end
    eng_addr = 12'h0A5; #1;
    tests_run++; if (ram_addr !== 12'h0A5 || ram_we !== 1'b0) begin fails++; $display("FAIL normal_run_mux got addr=%h we=%b exp 0a5/0", ram_addr, ram_we); end
    eng_done = 1'b1; tick; eng_done = 1'b0;
    tests_run++; if (done !== 1'b1 || err !== 2'd0) begin fails++; $display("FAIL normal_done got done=%b err=%0d exp 1/0", done, err); end
    tests_run++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || eng_rst !== 1'b1) begin fails++; $display("FAIL normal_done_state got busy=%b cfg_ready=%b rst=%b exp 0/1/1", busy, cfg_ready, eng_rst); end
    tick;
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL normal_done_held got=%b exp 1", done); end
    send_cfg(12'd4, 4'd2, 8'd3, 4'd5);
    tests_run++; if (done !== 1'b0 || ld_ready !== 1'b0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL normal_done_to_idle got done=%b ld_ready=%b cfg_ready=%b exp 0/0/1", done, ld_ready, cfg_ready); end
    tests_run++; if (wq.size() != 0) begin fails++; $display("FAIL normal_writes_missing got=%0d exp 0", wq.size()); end
  endtask

  task automatic test_bad_cfg;
    apply_reset;
    send_cfg(12'd0, 4'd2, 8'd3, 4'd1);
    tests_run++; if (err !== 2'd1 || ld_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL badcfg_points got err=%0d ld_ready=%b busy=%b exp 1/0/0", err, ld_ready, busy); end
    abort = 1'b1; tick; abort = 1'b0;
    tests_run++; if (err !== 2'd1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL badcfg_abort_keeps_err got err=%0d cfg_ready=%b exp 1/1", err, cfg_ready); end
    send_cfg(12'd3, 4'd2, 8'd1, 4'd1);
    tests_run++; if (err !== 2'd0 || ld_ready !== 1'b1) begin fails++; $display("FAIL badcfg_good_clears got err=%0d ld_ready=%b exp 0/1", err, ld_ready); end
    abort = 1'b1; tick; abort = 1'b0;
    send_cfg(12'd3, 4'd0, 8'd1, 4'd1);
    tests_run++; if (err !== 2'd1) begin fails++; $display("FAIL badcfg_feat got err=%0d exp 1", err); end
    abort = 1'b1; tick; abort = 1'b0;
    send_cfg(12'd3, 4'd2, 8'd1, 4'd1);
    abort = 1'b1; tick; abort = 1'b0;
    send_cfg(12'd3, 4'd2, 8'd0, 4'd1);
    tests_run++; if (err !== 2'd1 || ld_ready !== 1'b0) begin fails++; $display("FAIL badcfg_epoch got err=%0d ld_ready=%b exp 1/0", err, ld_ready); end
  endtask

  task automatic test_short_load;
    apply_reset;
    send_cfg(12'd8, 4'd3, 8'd1, 4'd0);
    for (int i = 0; i < 5; i++) send_beat(i, (i == 4), 1'b1);
    tests_run++; if (err !== 2'd2 || ld_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL short_err got err=%0d ld_ready=%b busy=%b exp 2/0/0", err, ld_ready, busy); end
    tick;
    tests_run++; if (wq.size() != 0 || ram_we !== 1'b0) begin fails++; $display("FAIL short_writes got pending=%0d we=%b exp 0/0", wq.size(), ram_we); end
  endtask

  task automatic test_watchdog;
    logic ok;
    int   run_cycles;
    apply_reset;
    send_cfg(12'd2, 4'd1, 8'd1, 4'd0);
    send_beat(0, 1'b0, 1'b1);
    send_beat(1, 1'b1, 1'b1);
    start = 1'b1;
    wait_run(ok);
    start = 1'b0;
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL wd_run_timeout got eng_rst=%b exp 0", eng_rst); end
    run_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (eng_rst === 1'b0) run_cycles++;
      else break;
    end
    tests_run++; if (run_cycles != 24) begin fails++; $display("FAIL wd_run_cycles got=%0d exp 24", run_cycles); end
    tests_run++; if (err !== 2'd3 || eng_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL wd_expire got err=%0d hold=%b done=%b exp 3/1/0", err, eng_hold, done); end
    tick;
    tests_run++; if (eng_hold !== 1'b0) begin fails++; $display("FAIL wd_hold_width got=%b exp 0", eng_hold); end
    tests_run++; if (wq.size() != 0) begin fails++; $display("FAIL wd_writes_missing got=%0d exp 0", wq.size()); end
  endtask

  task automatic test_abort_run;
    logic ok;
    apply_reset;
    send_cfg(12'd1, 4'd1, 8'd2, 4'd0);
    send_beat(0, 1'b0, 1'b1);
    start = 1'b1;
    wait_run(ok);
    start = 1'b0;
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL abort_run_timeout got eng_rst=%b exp 0", eng_rst); end
    eng_done = 1'b1; abort = 1'b1; tick; eng_done = 1'b0; abort = 1'b0;
    tests_run++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_idle got cfg_ready=%b busy=%b done=%b exp 1/0/0", cfg_ready, busy, done); end
    tests_run++; if (eng_hold !== 1'b1 || err !== 2'd0) begin fails++; $display("FAIL abort_hold got hold=%b err=%0d exp 1/0", eng_hold, err); end
    tick;
    tests_run++; if (eng_hold !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_after got hold=%b done=%b exp 0/0", eng_hold, done); end
  endtask

  task automatic test_arm_start;
    logic ok;
    apply_reset;
    send_cfg(12'd1, 4'd1, 8'd1, 4'd0);
    send_beat(0, 1'b0, 1'b1);
    tests_run++; if (eng_rst !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL arm_first got rst=%b busy=%b exp 1/1", eng_rst, busy); end
    start = 1'b1; tick; start = 1'b0;
    tests_run++; if (eng_rst !== 1'b1) begin fails++; $display("FAIL arm_early_run got rst=%b exp 1", eng_rst); end
    wait_run(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL arm_pending_lost got eng_rst=%b exp 0", eng_rst); end
    eng_addr = 12'h123; #1;
    tests_run++; if (ram_addr !== 12'h123) begin fails++; $display("FAIL arm_run_mux got=%h exp 123", ram_addr); end
    abort = 1'b1; tick; abort = 1'b0;
    tests_run++; if (eng_hold !== 1'b1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL arm_abort got hold=%b cfg_ready=%b exp 1/1", eng_hold, cfg_ready); end
  endtask

  task automatic test_rst_mid_load;
    apply_reset;
    send_cfg(12'd4, 4'd1, 8'd1, 4'd0);
    send_beat(0, 1'b0, 1'b1);
    ld_valid = 1'b1; ld_data = {DW/32{32'hDEADBEEF}}; RST = 1'b1;
    tick;
    ld_valid = 1'b0; RST = 1'b0;
    tests_run++; if (ram_we !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_load got we=%b busy=%b cfg_ready=%b exp 0/0/1", ram_we, busy, cfg_ready); end
    tests_run++; if (eng_points !== '0 || err !== 2'd0) begin fails++; $display("FAIL rst_load_regs got pts=%0d err=%0d exp 0/0", eng_points, err); end
    tick;
    tests_run++; if (wq.size() != 0) begin fails++; $display("FAIL rst_load_writes got=%0d exp 0", wq.size()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_cfg();
    test_short_load();
    test_watchdog();
    test_abort_run();
    test_arm_start();
    test_rst_mid_load();
    tick;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
